// File: rtl/rotary_quad_gen_pkg.sv
// Shared definitions for the rotary-encoder emulator: FSM states,
// quadrature phase tables and the detent level.
package rotary_quad_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROTATE,
        ST_PRESS,
        ST_GAP
    } rot_state_t;

    localparam logic [1:0] ROT_DETENT = 2'b11;

    // Phase p of a detent step lives in bits [2p+1:2p]; {A,B} per entry.
    localparam logic [7:0] CW_TABLE  = {2'b11, 2'b10, 2'b00, 2'b01};
    localparam logic [7:0] CCW_TABLE = {2'b11, 2'b01, 2'b00, 2'b10};

    function automatic logic [1:0] quad_phase(input logic dir, input logic [1:0] p);
        logic [7:0] tbl;
        tbl = dir ? CW_TABLE : CCW_TABLE;
        return tbl[{p, 1'b0} +: 2];
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rotary_quad_gen_tick_timer.sv
// Loadable down-counter; expire is high while the count sits at zero,
// so a load of L expires on the (L+1)th edge after loading.
module tick_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign expire = (count_reg == '0);

endmodule

// File: rtl/rotary_quad_gen.sv
// Rotary-encoder emulator: turns step/press commands into quadrature A/B
// waveforms and an active-low push level, with a trailing detent gap.
module rotary_quad_gen
    import rotary_quad_gen_pkg::*;
#(
    parameter int PHASE_CYCLES = 27000,
    parameter int PRESS_CYCLES = 270000,
    parameter int CNT_W        = 8
) (
    input  logic             Fg_clk,
    input  logic             Reset,
    input  logic             Cmd_valid,
    output logic             Cmd_ready,
    input  logic             Cmd_dir,
    input  logic [CNT_W-1:0] Cmd_steps,
    input  logic             Cmd_press,
    output logic             Busy,
    output logic [CNT_W-1:0] Steps_left,
    output logic             Cmd_done,
    output logic             Rot_A,
    output logic             Rot_B,
    output logic             Rot_C
);

    localparam int TW = $clog2(max_int(PHASE_CYCLES, PRESS_CYCLES) + 1);

    // Outputs trail the state by one register stage, so phases and press
    // load N-1 while the gap loads N to absorb that extra cycle.
    localparam logic [TW-1:0] PHASE_LOAD = TW'(PHASE_CYCLES - 1);
    localparam logic [TW-1:0] PRESS_LOAD = TW'(PRESS_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'(PHASE_CYCLES);

    rot_state_t       state_reg, state_next;
    logic [1:0]       phase_reg, phase_next;
    logic             dir_reg, dir_next;
    logic             press_reg, press_next;
    logic [CNT_W-1:0] steps_left_reg, steps_left_next;
    logic [1:0]       ab_reg, ab_next;
    logic             c_reg, c_next;
    logic             ready_reg, ready_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic             tmr_expire;

    tick_timer #(.W(TW)) u_timer (
        .clk      (Fg_clk),
        .rst      (Reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    always_ff @(posedge Fg_clk or posedge Reset) begin
        if (Reset) begin
            state_reg      <= ST_IDLE;
            phase_reg      <= 2'd0;
            dir_reg        <= 1'b0;
            press_reg      <= 1'b0;
            steps_left_reg <= '0;
            ab_reg         <= ROT_DETENT;
            c_reg          <= 1'b1;
            ready_reg      <= 1'b0;
            busy_reg       <= 1'b1;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            phase_reg      <= phase_next;
            dir_reg        <= dir_next;
            press_reg      <= press_next;
            steps_left_reg <= steps_left_next;
            ab_reg         <= ab_next;
            c_reg          <= c_next;
            ready_reg      <= ready_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        phase_next      = phase_reg;
        dir_next        = dir_reg;
        press_next      = press_reg;
        steps_left_next = steps_left_reg;
        ready_next      = 1'b0;
        done_next       = 1'b0;
        tmr_load        = 1'b0;
        tmr_val         = PHASE_LOAD;

        case (state_reg)
            ST_IDLE: begin
                ready_next = 1'b1;
                if (Cmd_valid && ready_reg) begin
                    ready_next      = 1'b0;
                    dir_next        = Cmd_dir;
                    press_next      = Cmd_press;
                    steps_left_next = Cmd_steps;
                    phase_next      = 2'd0;
                    tmr_load        = 1'b1;
                    if (Cmd_steps != '0) begin
                        state_next = ST_ROTATE;
                        tmr_val    = PHASE_LOAD;
                    end else if (Cmd_press) begin
                        state_next = ST_PRESS;
                        tmr_val    = PRESS_LOAD;
                    end else begin
                        state_next = ST_GAP;
                        tmr_val    = GAP_LOAD;
                    end
                end
            end
            ST_ROTATE: begin
                // Count the step on the edge that drives {A,B} back to detent.
                if (phase_reg == 2'd3 && ab_reg != ROT_DETENT && steps_left_reg != '0) begin
                    steps_left_next = steps_left_reg - CNT_W'(1);
                end
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    if (phase_reg == 2'd3 && steps_left_reg == '0) begin
                        if (press_reg) begin
                            state_next = ST_PRESS;
                            tmr_val    = PRESS_LOAD;
                        end else begin
                            state_next = ST_GAP;
                            tmr_val    = GAP_LOAD;
                        end
                    end else begin
                        phase_next = phase_reg + 2'd1;
                        tmr_val    = PHASE_LOAD;
                    end
                end
            end
            ST_PRESS: begin
                if (tmr_expire) begin
                    state_next = ST_GAP;
                    tmr_load   = 1'b1;
                    tmr_val    = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (tmr_expire) begin
                    state_next = ST_IDLE;
                    ready_next = 1'b1;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = ~ready_next;
        ab_next   = (state_reg == ST_ROTATE) ? quad_phase(dir_reg, phase_reg) : ROT_DETENT;
        c_next    = (state_reg != ST_PRESS);
    end

    assign Cmd_ready  = ready_reg;
    assign Busy       = busy_reg;
    assign Cmd_done   = done_reg;
    assign Steps_left = steps_left_reg;
    assign Rot_A      = ab_reg[1];
    assign Rot_B      = ab_reg[0];
    assign Rot_C      = c_reg;

endmodule

// File: tb/tb_rotary_quad_gen.sv
// Bench for rotary_quad_gen: per-cycle comparison against a timeline model
// derived from command parameters, plus a quadrature decoder on the pins.
module tb_rotary_quad_gen;

    localparam int PC  = 4;
    localparam int PRS = 6;
    localparam int CW  = 8;

    logic          Fg_clk = 1'b0;
    logic          Reset;
    logic          Cmd_valid;
    logic          Cmd_ready;
    logic          Cmd_dir;
    logic [CW-1:0] Cmd_steps;
    logic          Cmd_press;
    logic          Busy;
    logic [CW-1:0] Steps_left;
    logic          Cmd_done;
    logic          Rot_A, Rot_B, Rot_C;

    int vectors     = 0;
    int miscompares = 0;
    int dec_net     = 0;
    int dec_illegal = 0;
    int exp_net     = 0;
    logic [1:0] dec_prev = 2'b11;

    logic [1:0] cw_seq  [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
    logic [1:0] ccw_seq [4] = '{2'b10, 2'b00, 2'b01, 2'b11};

    rotary_quad_gen #(
        .PHASE_CYCLES (PC),
        .PRESS_CYCLES (PRS),
        .CNT_W        (CW)
    ) dut (
        .Fg_clk     (Fg_clk),
        .Reset      (Reset),
        .Cmd_valid  (Cmd_valid),
        .Cmd_ready  (Cmd_ready),
        .Cmd_dir    (Cmd_dir),
        .Cmd_steps  (Cmd_steps),
        .Cmd_press  (Cmd_press),
        .Busy       (Busy),
        .Steps_left (Steps_left),
        .Cmd_done   (Cmd_done),
        .Rot_A      (Rot_A),
        .Rot_B      (Rot_B),
        .Rot_C      (Rot_C)
    );

    always #5 Fg_clk = ~Fg_clk;

    // Reference detent decoder: +1 per CW detent (10->11), -1 per CCW (01->11).
    always @(negedge Fg_clk) begin
        if (Reset) begin
            dec_prev = 2'b11;
        end else begin
            if ({Rot_A, Rot_B} != dec_prev) begin
                if (({Rot_A, Rot_B} ^ dec_prev) == 2'b11) dec_illegal++;
                else if (dec_prev == 2'b10 && {Rot_A, Rot_B} == 2'b11) dec_net++;
                else if (dec_prev == 2'b01 && {Rot_A, Rot_B} == 2'b11) dec_net--;
            end
            dec_prev = {Rot_A, Rot_B};
        end
    end

    function automatic logic [31:0] observed();
        return {18'd0, Rot_A, Rot_B, Rot_C, Busy, Cmd_ready, Cmd_done, Steps_left};
    endfunction

    function automatic int done_offset(input int n, input bit press);
        return 1 + 4 * n * PC + (press ? PRS : 0) + PC;
    endfunction

    // Expected pin/status vector t cycles after the accepting edge.
    function automatic logic [31:0] model(input bit dir, input int n, input bit press, input int t);
        int rot_end, ph, completed, dt;
        logic [1:0] ab;
        bit c, rdy;
        rot_end = 4 * n * PC;
        ab = 2'b11;
        if (t >= 1 && t <= rot_end) begin
            ph = ((t - 1) / PC) % 4;
            ab = dir ? cw_seq[ph] : ccw_seq[ph];
        end
        c = !(press && t > rot_end && t <= rot_end + PRS);
        completed = 0;
        if (t - 1 >= 3 * PC) completed = (t - 1 - 3 * PC) / (4 * PC) + 1;
        if (completed > n) completed = n;
        dt  = done_offset(n, press);
        rdy = (t == dt);
        return {18'd0, ab, c, !rdy, rdy, rdy, 8'(n - completed)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller is #1 after an edge with Cmd_ready high; leaves the bench at
    // #1 after the Cmd_done edge, so a following call is back-to-back.
    task automatic run_cmd(input bit dir, input int n, input bit press);
        int dt;
        dt = done_offset(n, press);
        Cmd_valid = 1'b1;
        Cmd_dir   = dir;
        Cmd_steps = 8'(n);
        Cmd_press = press;
        @(posedge Fg_clk);
        #1;
        exp_net += dir ? n : -n;
        for (int t = 1; t <= dt; t++) begin
            Cmd_valid = 1'($urandom_range(0, 1));
            Cmd_dir   = 1'($urandom_range(0, 1));
            Cmd_steps = 8'($urandom_range(0, 255));
            Cmd_press = 1'($urandom_range(0, 1));
            @(posedge Fg_clk);
            #1;
            chk($sformatf("cmd dir=%0d n=%0d p=%0d t=%0d", dir, n, press, t),
                observed(), model(dir, n, press, t));
        end
        Cmd_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int m);
        for (int i = 0; i < m; i++) begin
            @(posedge Fg_clk);
            #1;
            chk("idle", observed(), {18'd0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0});
        end
    endtask

    initial begin
        Reset     = 1'b1;
        Cmd_valid = 1'b0;
        Cmd_dir   = 1'b0;
        Cmd_steps = '0;
        Cmd_press = 1'b0;
        repeat (2) @(posedge Fg_clk);
        #1;
        chk("reset_state", observed(), {18'd0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
        @(negedge Fg_clk);
        Reset = 1'b0;
        idle_cycles(1);

        run_cmd(1'b1, 1, 1'b0);
        idle_cycles(2);
        run_cmd(1'b0, 2, 1'b0);
        run_cmd(1'($urandom_range(0, 1)), 0, 1'b1);
        run_cmd(1'($urandom_range(0, 1)), 0, 1'b0);
        run_cmd(1'b1, 2, 1'b1);
        idle_cycles(1);

        for (int i = 0; i < 10; i++) begin
            run_cmd(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
        end
        run_cmd(1'b1, 3, 1'b0);
        idle_cycles(1);

        chk("decode_net", 32'(dec_net), 32'(exp_net));
        chk("decode_illegal", 32'(dec_illegal), 32'd0);

        // Reset while {A,B}=00 in the first step of a CW command.
        Cmd_valid = 1'b1;
        Cmd_dir   = 1'b1;
        Cmd_steps = 8'd2;
        Cmd_press = 1'b0;
        @(posedge Fg_clk);
        #1;
        Cmd_valid = 1'b0;
        repeat (PC + 2) @(posedge Fg_clk);
        #1;
        chk("pre_reset_rotate", observed(), model(1'b1, 2, 1'b0, PC + 2));
        #2;
        Reset = 1'b1;
        #1;
        chk("async_reset", observed(), {18'd0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
        @(negedge Fg_clk);
        Reset = 1'b0;
        idle_cycles(1);
        run_cmd(1'b0, 1, 1'b1);
        idle_cycles(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
